// File: rtl/spi_tx_arbiter.sv
// rtl/spi_tx_arbiter.sv - round-robin byte launcher in front of spi_final
// Define SPI_ARB_FIXED_PRI_EN to make the lowest requester index always win.
module spi_tx_arbiter #(
    parameter int NREQ         = 4,
    parameter int GAP_CYCLES   = 30,
    parameter int PULSE_CYCLES = 1
) (
    input  logic                    m_clk,
    input  logic                    n_reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*8-1:0]       req_data,
    output logic [NREQ-1:0]         ack,
    output logic [7:0]              data_in,
    output logic                    data_av,
    output logic [$clog2(NREQ)-1:0] grant_id,
    output logic                    busy
);

    localparam int IDW     = $clog2(NREQ);
    localparam int CNT_MAX = (GAP_CYCLES > PULSE_CYCLES) ? GAP_CYCLES : PULSE_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_HOLD   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_next;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_grant_id;
    logic [NREQ-1:0] r_ack;
    logic [7:0]      r_data_in;
    logic            r_data_av;
    logic            w_found;
    logic [IDW-1:0]  w_win;
    logic            w_grant;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
`ifdef SPI_ARB_FIXED_PRI_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                w_found = 1'b1;
                w_win   = IDW'(k);
            end
        end
`else
        // Walk from the slot after the last winner so every requester gets a turn.
        for (int k = 1; k <= NREQ; k++) begin
            if (!w_found && req[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_win   = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
`endif
    end

    assign w_grant = (r_state == S_IDLE) && w_found;

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next_state = S_LAUNCH;
                    w_cnt_next   = CW'(PULSE_CYCLES);
                end
            end
            S_LAUNCH: begin
                if (r_cnt <= CW'(1)) begin
                    w_next_state = S_HOLD;
                    w_cnt_next   = CW'(GAP_CYCLES);
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            S_HOLD: begin
                if (r_cnt <= CW'(1)) begin
                    w_next_state = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt - CW'(1);
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_ptr      <= IDW'(NREQ - 1);
            r_grant_id <= '0;
            r_ack      <= '0;
            r_data_in  <= 8'h00;
            r_data_av  <= 1'b0;
        end else begin
            r_ack     <= '0;
            r_data_av <= (w_next_state == S_LAUNCH);
            if (w_grant) begin
                r_ack      <= NREQ'(1) << w_win;
                r_data_in  <= req_data[int'(w_win)*8 +: 8];
                r_grant_id <= w_win;
                r_ptr      <= w_win;
            end
        end
    end

    assign ack      = r_ack;
    assign data_in  = r_data_in;
    assign data_av  = r_data_av;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// tb/tb_spi_tx_arbiter.sv - directed checks of spi_tx_arbiter at default parameters
module tb_spi_tx_arbiter;

    logic        m_clk = 1'b0;
    logic        n_reset;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [7:0]  data_in;
    logic        data_av;
    logic [1:0]  grant_id;
    logic        busy;

    int n_cmp = 0;
    int n_mis = 0;

    spi_tx_arbiter #(.NREQ(4), .GAP_CYCLES(30), .PULSE_CYCLES(1)) u_dut (
        .m_clk    (m_clk),
        .n_reset  (n_reset),
        .req      (req),
        .req_data (req_data),
        .ack      (ack),
        .data_in  (data_in),
        .data_av  (data_av),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 m_clk = ~m_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge m_clk);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         exp_rr[5];
        logic [3:0] ack_seen;
`ifdef SPI_ARB_FIXED_PRI_EN
        exp_rr = '{0, 0, 0, 0, 0};
`else
        exp_rr = '{0, 1, 2, 3, 0};
`endif
        n_reset  = 1'b0;
        req      = 4'b1111;
        req_data = {8'h13, 8'h12, 8'h11, 8'h10};

        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_av", 32'(data_av), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_data", 32'(data_in), 32'd0);
            chk("rst_gid", 32'(grant_id), 32'd0);
        end

        // First grant, then four more with req held at 4'b1111.
        n_reset = 1'b1;
        tick();
        chk("rr_ack0", 32'(ack), 32'd1 << exp_rr[0]);
        chk("rr_data0", 32'(data_in), 32'h10 + 32'(exp_rr[0]));
        chk("rr_av0", 32'(data_av), 32'd1);
        chk("rr_busy0", 32'(busy), 32'd1);
        chk("rr_gid0", 32'(grant_id), 32'(exp_rr[0]));
        for (int g = 1; g < 5; g++) begin
            for (int i = 2; i <= 32; i++) begin
                tick();
                if (i == 2) begin
                    chk("rr_av_drop", 32'(data_av), 32'd0);
                    chk("rr_ack_drop", 32'(ack), 32'd0);
                end
                if (i == 31) chk("rr_busy_hold", 32'(busy), 32'd1);
                if (i == 32) begin
                    chk("rr_busy_fall", 32'(busy), 32'd0);
                    chk("rr_no_ack", 32'(ack), 32'd0);
                end
            end
            tick();
            chk("rr_ack", 32'(ack), 32'd1 << exp_rr[g]);
            chk("rr_data", 32'(data_in), 32'h10 + 32'(exp_rr[g]));
            chk("rr_gid", 32'(grant_id), 32'(exp_rr[g]));
            chk("rr_av", 32'(data_av), 32'd1);
        end

        // Single request from requester 2.
        req = 4'b0000;
        wait_idle();
        req = 4'b0100;
        req_data[23:16] = 8'h5A;
        tick();
        req = 4'b0000;
        chk("one_ack", 32'(ack), 32'h4);
        chk("one_data", 32'(data_in), 32'h5A);
        chk("one_av", 32'(data_av), 32'd1);
        chk("one_gid", 32'(grant_id), 32'd2);
        chk("one_busy", 32'(busy), 32'd1);
        tick();
        chk("one_ack_pulse", 32'(ack), 32'd0);
        chk("one_av_pulse", 32'(data_av), 32'd0);
        for (int i = 3; i <= 32; i++) begin
            tick();
            if (i == 31) chk("one_busy_t31", 32'(busy), 32'd1);
        end
        chk("one_busy_t32", 32'(busy), 32'd0);
        chk("one_data_hold", 32'(data_in), 32'h5A);
        chk("one_gid_hold", 32'(grant_id), 32'd2);

        // Late arrival: requester 1 rises at t+10, while the requester 0 byte is in HOLD.
        req = 4'b0001;
        tick();
        req = 4'b0000;
        chk("late_first_ack", 32'(ack), 32'h1);
        ack_seen = 4'b0000;
        for (int i = 2; i <= 32; i++) begin
            tick();
            if (i == 10) begin
                req = 4'b0010;
                req_data[15:8] = 8'h77;
            end
            if (i > 10) ack_seen = ack_seen | ack;
        end
        chk("late_no_early_ack", 32'(ack_seen), 32'd0);
        tick();
        chk("late_ack_t33", 32'(ack), 32'h2);
        chk("late_data", 32'(data_in), 32'h77);
        chk("late_gid", 32'(grant_id), 32'd1);

        // Reset during LAUNCH, then requesters 1 and 3 compete.
        n_reset  = 1'b0;
        req      = 4'b1010;
        req_data[31:24] = 8'h33;
        tick();
        chk("mid_rst_av", 32'(data_av), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ack", 32'(ack), 32'd0);
        chk("mid_rst_data", 32'(data_in), 32'd0);
        n_reset = 1'b1;
        tick();
        chk("mid_rst_grant", 32'(ack), 32'h2);
        chk("mid_rst_gid", 32'(grant_id), 32'd1);
        chk("mid_rst_gdata", 32'(data_in), 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
